// File: rtl/team_06_tremelo_demod.sv
// Tremolo demodulator / level restorer.
// Tracks an attack/release envelope and rescales each sample to TARGET.
module team_06_tremelo_demod #(
  parameter logic [7:0]  TARGET        = 8'd200,
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 5
) (
  input  logic       clkdiv,
  input  logic       rst,
  input  logic       en,
  input  logic       sample_valid,
  input  logic [7:0] audio_in,
  output logic [7:0] audio_out,
  output logic       out_valid,
  output logic [7:0] envelope,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ENV,
    DIV,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sample_q, sample_d;
  logic [7:0]  env_q, env_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  out_q, out_d;
  logic        ov_q, ov_d;

  logic [7:0]  env_next;
  logic [7:0]  diff;
  logic [7:0]  step;
  logic [8:0]  trial;
  logic        qbit;

  // Envelope step: shifted difference, never less than 1, never past the sample.
  always_comb begin
    env_next = env_q;
    diff     = 8'd0;
    step     = 8'd0;
    if (sample_q > env_q) begin
      diff     = sample_q - env_q;
      step     = diff >> ATTACK_SHIFT;
      if (step == 8'd0) step = 8'd1;
      env_next = env_q + step;
    end else if (sample_q < env_q) begin
      diff     = env_q - sample_q;
      step     = diff >> RELEASE_SHIFT;
      if (step == 8'd0) step = 8'd1;
      env_next = env_q - step;
    end
  end

  // Next-state, envelope update and restoring-divider datapath.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    env_d    = env_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ov_d     = 1'b0;
    trial    = {rem_q, quo_q[15]};
    qbit     = (trial >= {1'b0, div_q});
    unique case (state_q)
      IDLE: begin
        if (sample_valid) begin
          if (en) begin
            sample_d = audio_in;
            state_d  = ENV;
          end else begin
            out_d = audio_in;
            ov_d  = 1'b1;
          end
        end
      end
      ENV: begin
        env_d   = env_next;
        quo_d   = {8'd0, TARGET} * {8'd0, sample_q};
        rem_d   = 8'd0;
        div_d   = env_next;
        cnt_d   = 4'd0;
        state_d = DIV;
      end
      DIV: begin
        if (qbit) begin
          rem_d = 8'(trial - {1'b0, div_q});
        end else begin
          rem_d = trial[7:0];
        end
        quo_d = {quo_q[14:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          ov_d    = 1'b1;
          if (div_q == 8'd0) begin
            out_d = 8'd0;
          end else if (quo_d[15:8] != 8'd0) begin
            out_d = 8'd255;
          end else begin
            out_d = quo_d[7:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clkdiv) begin
    if (!rst) begin
      state_q  <= IDLE;
      sample_q <= 8'd0;
      env_q    <= 8'd0;
      rem_q    <= 8'd0;
      quo_q    <= 16'd0;
      div_q    <= 8'd0;
      cnt_q    <= 4'd0;
      out_q    <= 8'd0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      env_q    <= env_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ov_q     <= ov_d;
    end
  end

  assign audio_out = out_q;
  assign out_valid = ov_q;
  assign envelope  = env_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_team_06_tremelo_demod.sv
// Bench for the tremolo demodulator.
// Directed vectors plus a per-cycle reference model.
module tb_team_06_tremelo_demod;

  localparam int TGT = 200;
  localparam int ASH = 2;
  localparam int RSH = 5;

  logic       clkdiv = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] audio_in = 8'd0;
  logic [7:0] audio_out;
  logic       out_valid;
  logic [7:0] envelope;
  logic       busy;

  team_06_tremelo_demod dut (
    .clkdiv       (clkdiv),
    .rst          (rst),
    .en           (en),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .envelope     (envelope),
    .busy         (busy)
  );

  always #5 clkdiv = ~clkdiv;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: whole-sample arithmetic, timed by cycles since accept.
  int m_env = 0;
  int m_out = 0;
  int m_valid = 0;
  int m_busy = 0;
  int m_t = 0;
  int m_s = 0;
  int m_pend = 0;

  function automatic int next_env(input int e, input int s);
    int d;
    if (s > e) begin
      d = (s - e) >> ASH;
      return e + ((d == 0) ? 1 : d);
    end else if (s < e) begin
      d = (e - s) >> RSH;
      return e - ((d == 0) ? 1 : d);
    end
    return e;
  endfunction

  function automatic int scaled(input int s, input int e);
    int q;
    if (e == 0) return 0;
    q = (TGT * s) / e;
    return (q > 255) ? 255 : q;
  endfunction

  always @(posedge clkdiv) begin
    if (!rst) begin
      m_env = 0; m_out = 0; m_valid = 0; m_busy = 0; m_t = 0;
    end else begin
      m_valid = 0;
      if (m_t == 0) begin
        if (sample_valid) begin
          if (en) begin
            m_s = audio_in;
            m_t = 1;
          end else begin
            m_out = audio_in;
            m_valid = 1;
          end
        end
      end else begin
        if (m_t == 1) begin
          m_env = next_env(m_env, m_s);
          m_pend = scaled(m_s, m_env);
        end
        if (m_t == 17) begin
          m_out = m_pend;
          m_valid = 1;
        end
        m_t = (m_t == 18) ? 0 : m_t + 1;
      end
      m_busy = (m_t != 0);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clkdiv) begin
    if (cmp_on) begin
      chk("m_out_valid", out_valid, m_valid);
      chk("m_busy", busy, m_busy);
      chk("m_envelope", envelope, m_env);
      chk("m_audio_out", audio_out, m_out);
    end
  end

  task automatic send(input logic [7:0] v, input logic e);
    @(negedge clkdiv);
    sample_valid = 1'b1;
    audio_in = v;
    en = e;
    @(negedge clkdiv);
    sample_valid = 1'b0;
  endtask

  task automatic run_sample(input logic [7:0] v, input bit lit,
                            input int e_env, input int e_out,
                            input string tag);
    send(v, 1'b1);
    @(negedge clkdiv);
    if (lit) chk({tag, "_env_n2"}, envelope, e_env);
    repeat (16) @(negedge clkdiv);
    if (lit) begin
      chk({tag, "_valid_n18"}, out_valid, 1);
      chk({tag, "_out_n18"}, audio_out, e_out);
    end
    @(negedge clkdiv);
    if (lit) chk({tag, "_idle_n19"}, busy, 0);
  endtask

  int cnt;

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clkdiv);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_envelope", envelope, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    cmp_on = 1'b1;

    run_sample(8'd100, 1'b1, 25, 255, "first");

    for (int i = 0; i < 32; i++) begin
      run_sample(8'd100, (i == 31), 100, 200, "conv");
    end
    chk("conv_hold_out", audio_out, 200);

    run_sample(8'd4, 1'b1, 97, 8, "release");

    send(8'd100, 1'b1);
    repeat (3) @(negedge clkdiv);
    @(negedge clkdiv);
    sample_valid = 1'b1;
    audio_in = 8'd50;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkdiv);
      if (out_valid) cnt++;
    end
    chk("drop_pulses", cnt, 1);
    chk("drop_env", envelope, 98);
    chk("drop_out", audio_out, 204);

    @(negedge clkdiv);
    sample_valid = 1'b1;
    audio_in = 8'd77;
    en = 1'b0;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    chk("byp_valid", out_valid, 1);
    chk("byp_out", audio_out, 77);
    chk("byp_env", envelope, 98);
    @(negedge clkdiv);
    chk("byp_pulse_end", out_valid, 0);
    chk("byp_hold", audio_out, 77);

    send(8'd100, 1'b1);
    repeat (8) @(negedge clkdiv);
    @(negedge clkdiv);
    rst = 1'b0;
    @(negedge clkdiv);
    rst = 1'b1;
    chk("abort_env", envelope, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_out", audio_out, 0);
    sample_valid = 1'b1;
    audio_in = 8'd50;
    en = 1'b1;
    @(negedge clkdiv);
    sample_valid = 1'b0;
    chk("post_rst_accept", busy, 1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clkdiv);
      if (out_valid) cnt++;
    end
    chk("abort_no_pulse", cnt, 0);
    repeat (2) @(negedge clkdiv);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_out", audio_out, 255);
    chk("post_rst_env", envelope, 12);
    repeat (5) @(negedge clkdiv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
